uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   uart_state_t    : 2-bit frame-level state encoding (IDLE/START/DATA/STOP)
//   UART_DATA_BITS  : default payload width per frame
//   UART_OVERSAMPLE : default os_tick pulses per bit period
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous input.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset; both flops load RESET_VAL
//   d       : asynchronous input
//   q       : synchronized output (two clk of latency)
// RESET_VAL lets an idle-high line (e.g. UART rxd) come out of reset without
// showing a spurious falling edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_reg <= {2{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver (start bit, DATA_BITS LSB-first, one stop bit).
//   clk       : single clock, all state on rising edge
//   reset_n   : asynchronous active-low reset
//   os_tick   : one-clk enable, OVERSAMPLE pulses per bit period
//   rxd       : asynchronous serial line, idle high
//   rx_data   : last received byte, stable while rx_valid=1
//   rx_valid  : rx_data holds an unconsumed byte
//   rx_ready  : consumer accepts rx_data when rx_valid & rx_ready
//   rx_busy   : high whenever the receiver is not IDLE
//   frame_err : one-clk pulse when the stop bit samples low
//   overrun   : one-clk pulse when a good frame is dropped because rx_data is still unconsumed
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 os_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rxd_s;
  logic                 rxd_d_reg;
  uart_state_t          state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;
  logic                 fall_edge;
  logic                 handshake;

  // Line idles high, so the synchronizer and delay flop reset to 1: releasing
  // reset must not look like a start-bit edge.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rxd_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_d_reg <= 1'b1;
    end else begin
      rxd_d_reg <= rxd_s;
    end
  end

  // Edge (not level) detect: a line stuck low after a bad stop bit must
  // rise and fall again before a new frame can start.
  assign fall_edge = rxd_d_reg && !rxd_s;
  assign handshake = rx_valid_reg && rx_ready;

  // Sample counter wraps explicitly so non-power-of-two OVERSAMPLE works.
  assign cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;

      // A consumed byte clears; a good frame finishing this same cycle
      // overrides this below and reloads the output.
      if (handshake) begin
        rx_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (fall_edge) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end

        START: begin
          if (os_tick) begin
            if (cnt_reg == CNT_MID) begin
              cnt_reg <= '0;
              if (!rxd_s) begin
                // Start bit confirmed at mid-bit; data samples now land
                // one full bit period later, i.e. mid-bit of each data bit.
                state_reg   <= DATA;
                bit_idx_reg <= '0;
              end else begin
                // Line was back high by mid-bit: a glitch, not a frame.
                state_reg <= IDLE;
              end
            end else begin
              cnt_reg <= cnt_next;
            end
          end
        end

        DATA: begin
          if (os_tick) begin
            cnt_reg <= cnt_next;
            if (cnt_reg == CNT_LAST) begin
              shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
              if (bit_idx_reg == IDX_LAST) begin
                state_reg   <= STOP;
                bit_idx_reg <= '0;
              end else begin
                bit_idx_reg <= bit_idx_reg + IDX_W'(1);
              end
            end
          end
        end

        STOP: begin
          if (os_tick) begin
            cnt_reg <= cnt_next;
            if (cnt_reg == CNT_LAST) begin
              state_reg <= IDLE;
              if (!rxd_s) begin
                frame_err_reg <= 1'b1;
              end else if (!rx_valid_reg || rx_ready) begin
                rx_data_reg  <= shift_reg;
                rx_valid_reg <= 1'b1;
              end else begin
                // Previous byte still pending: keep it, drop the new one.
                overrun_reg <= 1'b1;
              end
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rx_busy   = (state_reg != IDLE);
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx (8 data bits, 16x oversample,
// os_tick held high so one bit period is 16 clk).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       os_tick = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Observation state, updated on the falling edge away from DUT updates.
  int         cyc = 0;
  int         fall_cyc = 0;
  int         rise_cyc = 0;
  int         ov_cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vcyc = 0;
  int         hs_n = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] hs_mem [0:15];

  int v0;
  int h0;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .os_tick   (os_tick),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    if (rx_valid) vcyc <= vcyc + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    // valid & ready here means the handshake happens at the next rising edge.
    if (rx_valid && rx_ready) begin
      hs_mem[hs_n[3:0]] <= rx_data;
      hs_n <= hs_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start bit, 8 data bits LSB-first, stop bit; each held 16 clk, changed on
  // the falling edge. The start-bit edge's posedge count is kept in fall_cyc.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    $display("send frame %02h stop=%0d", b, stop_bit);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) fall_cyc = cyc;
      rxd = bits[i];
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic consume_one();
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("idle_busy", 32'(rx_busy), 32'd0);

    // 0xA5 good frame: 2 sync + 1 edge + 8 to mid-start + 9*16 to the stop
    // sample = 155 clk from the falling edge to rx_valid rising.
    send_frame(8'hA5, 1'b1);
    @(posedge clk); #1;
    chk("a5_valid", 32'(rx_valid), 32'd1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_ferr", 32'(frame_err), 32'd0);
    chk("a5_fe_cnt", 32'(fe_cnt), 32'd0);
    chk("a5_latency", 32'(rise_cyc - fall_cyc), 32'd155);
    chk("a5_busy", 32'(rx_busy), 32'd0);
    consume_one();
    chk("a5_cleared", 32'(rx_valid), 32'd0);
    chk("a5_hs_n", 32'(hs_n), 32'd1);
    chk("a5_hs_data", 32'(hs_mem[0]), 32'hA5);
    $display("delivered %02h", hs_mem[0]);

    // 5-clk low glitch while idle
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("glitch_busy", 32'(rx_busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(posedge clk); #1;
    $display("glitch done");
    chk("glitch_idle", 32'(rx_busy), 32'd0);
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_fe", 32'(fe_cnt), 32'd0);
    chk("glitch_ov", 32'(ov_cnt), 32'd0);

    // 0x3C with stop bit low; line then stays low
    send_frame(8'h3C, 1'b0);
    repeat (5) @(posedge clk); #1;
    chk("ferr_cnt", 32'(fe_cnt), 32'd1);
    chk("ferr_valid", 32'(rx_valid), 32'd0);
    chk("ferr_data", 32'(rx_data), 32'hA5);
    chk("ferr_busy", 32'(rx_busy), 32'd0);
    repeat (60) @(posedge clk); #1;
    chk("ferr_no_retrig", 32'(rx_busy), 32'd0);
    chk("ferr_cnt_hold", 32'(fe_cnt), 32'd1);
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("ferr_rise_idle", 32'(rx_busy), 32'd0);

    // Overrun: 0x11 then 0x22 with rx_ready low
    send_frame(8'h11, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("ov_first_valid", 32'(rx_valid), 32'd1);
    chk("ov_first_data", 32'(rx_data), 32'h11);
    chk("ov_none_yet", 32'(ov_cnt), 32'd0);
    send_frame(8'h22, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("ov_data_kept", 32'(rx_data), 32'h11);
    chk("ov_valid", 32'(rx_valid), 32'd1);
    chk("ov_cnt", 32'(ov_cnt), 32'd1);
    chk("ov_timing", 32'(ov_cyc - fall_cyc), 32'd155);
    consume_one();
    chk("ov_hs_n", 32'(hs_n), 32'd2);
    chk("ov_hs_data", 32'(hs_mem[1]), 32'h11);
    chk("ov_cleared", 32'(rx_valid), 32'd0);
    $display("delivered %02h, one dropped", hs_mem[1]);

    // Back-to-back 0x55, 0xAA with rx_ready held high
    v0 = vcyc;
    h0 = hs_n;
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    repeat (5) @(posedge clk); #1;
    rx_ready = 1'b0;
    chk("b2b_hs_count", 32'(hs_n - h0), 32'd2);
    chk("b2b_first", 32'(hs_mem[2]), 32'h55);
    chk("b2b_second", 32'(hs_mem[3]), 32'hAA);
    chk("b2b_valid_cycles", 32'(vcyc - v0), 32'd2);
    $display("delivered %02h then %02h", hs_mem[2], hs_mem[3]);

    // Reset during DATA of 0xFF, then 0x0F
    fork
      send_frame(8'hFF, 1'b1);
    join_none
    repeat (60) @(posedge clk); #1;
    chk("mid_busy", 32'(rx_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_data", 32'(rx_data), 32'd0);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    chk("mid_rst_busy", 32'(rx_busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (150) @(posedge clk); #1;
    chk("abort_busy", 32'(rx_busy), 32'd0);
    chk("abort_valid", 32'(rx_valid), 32'd0);
    chk("abort_fe", 32'(fe_cnt), 32'd1);
    chk("abort_ov", 32'(ov_cnt), 32'd1);
    send_frame(8'h0F, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("post_valid", 32'(rx_valid), 32'd1);
    chk("post_data", 32'(rx_data), 32'h0F);
    chk("post_latency", 32'(rise_cyc - fall_cyc), 32'd155);
    $display("delivered %02h after reset", rx_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
